// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

  // Fault tag carried with every response; both bits may be set together.
  typedef struct packed {
    logic out_of_range;  // bit 1
    logic misaligned;    // bit 0
  } fault_t;

  localparam int unsigned FaultMisalignBit = 0;
  localparam int unsigned FaultRangeBit    = 1;

  // addi x0, x0, 0
  localparam logic [31:0] FAULT_INSTR_DEFAULT = 32'h0000_0013;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;

  function automatic fault_t make_fault(input logic misaligned, input logic out_of_range);
    fault_t f;
    f              = '0;
    f.misaligned   = misaligned;
    f.out_of_range = out_of_range;
    return f;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Fall-through response FIFO: an empty FIFO passes its input straight to the output,
// so it adds no cycle of latency. Synchronous flush empties it at the clock edge.
module imem_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign out_valid_o = ~empty | in_valid_i;
  assign out_data_o  = empty ? in_data_i : store_q[rd_ptr_q];
  assign pop         = ~empty & out_ready_i;
  // An input consumed directly on the bypass path is never stored.
  assign push        = in_valid_i & ~(empty & out_ready_i);

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      store_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Pipelined instruction memory for the fetch path. Byte-addressed requests are fault
// checked at acceptance, travel through LATENCY register stages and leave in order via
// a fall-through response FIFO. Optional program-load port: define IMEM_WRITE_PORT_EN.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned RSP_DEPTH   = 2,
  parameter logic [31:0] FAULT_INSTR = FAULT_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_instr_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [1:0]        rsp_fault_o
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [3:0]        wr_strb_i
`endif
);

  // Byte index width; a one-word memory still needs a word field to slice.
  localparam int unsigned IdxW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 3;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned RspW = 32 + ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_BYTES - 4);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("imem_fetch_port: LATENCY must be within 1..4");
  end
  if (RSP_DEPTH < LATENCY) begin : g_bad_rsp_depth
    $error("imem_fetch_port: RSP_DEPTH must be at least LATENCY");
  end
  if (DEPTH_BYTES < 4 || (DEPTH_BYTES % 4) != 0) begin : g_bad_depth
    $error("imem_fetch_port: DEPTH_BYTES must be a non-zero multiple of 4");
  end

  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept;
  logic              rsp_pop;
  fault_t            req_fault;
  logic [31:0]       rd_word;
  logic [31:0]       req_instr;

  logic [CntW-1:0]   outstanding_q, outstanding_d;

  logic [LATENCY-1:0] pipe_valid_q;
  logic [31:0]        pipe_instr_q [LATENCY];
  logic [ADDR_W-1:0]  pipe_addr_q  [LATENCY];
  fault_t             pipe_fault_q [LATENCY];

  logic [RspW-1:0]   fifo_in;
  logic [RspW-1:0]   fifo_out;

  // Outstanding never exceeds RSP_DEPTH, so the FIFO can absorb every in-flight read
  // and the pipeline itself never has to stall.
  assign req_ready_o = rst_n & ~flush_i & (outstanding_q < CntW'(RSP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;

  // Full-width range compare: high address bits must not alias into the array.
  assign req_fault = make_fault(|req_addr_i[1:0], req_addr_i > LastAddr);

  assign rd_word = {mem[{req_addr_i[IdxW-1:2], 2'd3}],
                    mem[{req_addr_i[IdxW-1:2], 2'd2}],
                    mem[{req_addr_i[IdxW-1:2], 2'd1}],
                    mem[{req_addr_i[IdxW-1:2], 2'd0}]};

  assign req_instr = (req_fault != '0) ? FAULT_INSTR : rd_word;

  // Outstanding count: accepted minus consumed; flush drops everything.
  always_comb begin
    outstanding_d = outstanding_q;
    if (flush_i) begin
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q + CntW'(accept) - CntW'(rsp_pop);
    end
  end

  // Outstanding count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // Read pipeline: stage 0 captures the checked fetch, later stages only delay it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_instr_q[i] <= '0;
        pipe_addr_q[i]  <= '0;
        pipe_fault_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= accept;
      if (accept) begin
        pipe_instr_q[0] <= req_instr;
        pipe_addr_q[0]  <= req_addr_i;
        pipe_fault_q[0] <= req_fault;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_instr_q[i] <= pipe_instr_q[i-1];
        pipe_addr_q[i]  <= pipe_addr_q[i-1];
        pipe_fault_q[i] <= pipe_fault_q[i-1];
      end
      if (flush_i) begin
        pipe_valid_q <= '0;
      end
    end
  end

`ifdef IMEM_WRITE_PORT_EN
  logic wr_ok;

  assign wr_ok = wr_en_i & (wr_addr_i[1:0] == 2'b00) & (wr_addr_i <= LastAddr);

  // Byte-strobed program load; nonblocking update gives read-before-write on a clash.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) begin
          mem[{wr_addr_i[IdxW-1:2], 2'(b)}] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end
`endif

  assign fifo_in = {pipe_instr_q[LATENCY-1], pipe_addr_q[LATENCY-1], pipe_fault_q[LATENCY-1]};

  imem_rsp_fifo #(
    .WIDTH (RspW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (pipe_valid_q[LATENCY-1]),
    .in_data_i   (fifo_in),
    .out_valid_o (rsp_valid_o),
    .out_ready_i (rsp_ready_i),
    .out_data_o  (fifo_out)
  );

  assign rsp_instr_o = fifo_out[RspW-1 -: 32];
  assign rsp_addr_o  = fifo_out[2 +: ADDR_W];
  assign rsp_fault_o = fifo_out[1:0];

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, pipelined instruction memory for the RISC-V fetch path. Accepts byte-addressed fetch requests over a valid/ready handshake and returns little-endian 32-bit instructions in order, after a configurable read latency, through a small response buffer. Misaligned and out-of-range fetches produce a fault-tagged NOP instead of a silent zero. Sits between the PC/fetch stage and decode; it replaces the single-cycle fetch memory.

## Interface
- `ADDR_W`, 32, request address width.
- `DEPTH_BYTES`, 1024, memory size in bytes; a multiple of 4, at least 4.
- `LATENCY`, 1, read pipeline stages from acceptance to response; legal range 1..4.
- `RSP_DEPTH`, 2, response buffer entries; must be ≥ `LATENCY`.
- `FAULT_INSTR`, 32'h00000013, instruction returned on a fault (addi x0,x0,0).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid_i`  in  1  fetch request valid.
- `req_ready_o`  out  1  request can be accepted.
- `req_addr_i`  in  `ADDR_W`  byte address (PC).
- `flush_i`  in  1  discard all in-flight and buffered responses.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  consumer accepts response.
- `rsp_instr_o`  out  32  instruction, `{mem[a+3],mem[a+2],mem[a+1],mem[a]}`.
- `rsp_addr_o`  out  `ADDR_W`  address of the request this response answers.
- `rsp_fault_o`  out  2  bit0 = misaligned, bit1 = out of range.

## Operation
- A request is accepted in any cycle where `req_valid_i & req_ready_o` is true.
- Fault check happens at acceptance:
  - Misaligned when `addr[1:0] != 0`.
  - Out of range when `addr > DEPTH_BYTES-4`, compared at full `ADDR_W` width with no truncation.
  - Both fault bits may be set together.
- When any fault bit is set, `rsp_instr_o = FAULT_INSTR` and the memory array is not read.
- Responses come out strictly in acceptance order.
- `outstanding` counts in-flight requests plus buffered responses.
  - It increments on acceptance and decrements on `rsp_valid_o & rsp_ready_i`; both can happen in the same cycle.
  - `req_ready_o = (outstanding < RSP_DEPTH) & ~flush_i`.
  - Overflow is therefore impossible by construction.
- Flush:
  - When `flush_i` is high, all pipeline stages and buffer entries are invalidated at that edge and `outstanding` goes to 0.
  - `rsp_valid_o` is 0 on the next cycle.
  - No request is accepted in the flush cycle.
  - A response handshaking in the flush cycle counts as consumed.
- `rsp_*` outputs hold stable while `rsp_valid_o & ~rsp_ready_i`.
- Memory contents are not reset.
- Reset while requests are outstanding drops every transaction.

## Timing
- While `rst_n` is low, and at the first edge after it goes low:
  - `rsp_valid_o=0`, `rsp_instr_o=0`, `rsp_addr_o=0`, `rsp_fault_o=0`, `outstanding=0`.
  - `req_ready_o=0` while `rst_n` is low.
- `req_ready_o=1` in the first cycle after `rst_n` returns high.
- A request accepted at edge N has `rsp_valid_o` high in cycle N+`LATENCY` at the earliest.
- The response buffer is fall-through, so an empty buffer adds no cycle.
- Sustained throughput is 1 request/cycle with `rsp_ready_i` held high, provided `RSP_DEPTH ≥ LATENCY+1`.
- With `RSP_DEPTH = LATENCY`, throughput drops to `LATENCY/(LATENCY+1)`; this is legal.
- Back-pressure: at most `RSP_DEPTH` outstanding. `req_ready_o` reasserts in the cycle after the pop that frees a slot.

## Configuration
- `IMEM_WRITE_PORT_EN` defined: adds a program-load port.
  - Ports: `wr_en_i` (1), `wr_addr_i` (`ADDR_W`), `wr_data_i` (32), `wr_strb_i` (4).
  - Word-aligned write with byte strobes, little-endian; `wr_strb_i[0]` selects byte `addr+0`.
  - Misaligned or out-of-range writes are ignored.
  - A same-cycle read of a written word returns the old data (read-before-write). The new data is visible to requests accepted one or more cycles later.
- Macro undefined: no write ports. The array is loadable only by initialisation (`$readmemh` hook in simulation). Read-path behaviour is identical either way.

## Structure
- Package `imem_pkg` holds:
  - Fault-code typedef and its bit positions.
  - `FAULT_INSTR` default constant.
  - `LATENCY` min/max constants.
- Sub-module `imem_rsp_fifo`: parametrised fall-through FIFO carrying `{instr, addr, fault}`, with a synchronous flush input.
- The top level holds:
  - Byte array.
  - Fault check.
  - `LATENCY`-stage valid/data pipeline.
  - `outstanding` counter.

## Test plan
- Reset, then with `LATENCY=1`, `rsp_ready_i=1`, requests to 0x0, 0x4, 0x8 on consecutive cycles (memory preloaded with 0x00500093, 0x00100113, 0x002081B3) → those words on three consecutive cycles starting one cycle after the first accept, `rsp_fault_o=0`.
- Request 0x6 → `rsp_instr_o=0x00000013`, `rsp_fault_o=2'b01`. Request 0x400 with `DEPTH_BYTES=1024` → fault `2'b10`. Request 0x3FD → fault `2'b11`.
- `LATENCY=3`, `RSP_DEPTH=3`, `rsp_ready_i=0`, continuous requests → exactly 3 accepted, `req_ready_o=0`. Raise `rsp_ready_i` → responses in order, with `req_ready_o` reasserting in the cycle after the first pop.
- With 2 in flight, assert `flush_i` for one cycle → no response for either, `rsp_valid_o=0` next cycle, and a fresh request to 0x10 returns `mem[0x10]` correctly.
- Assert `rst_n=0` mid-stream with 2 outstanding → all outputs at reset values next cycle, and no stale response after release.
- With `IMEM_WRITE_PORT_EN`: write 0xDEADBEEF to 0x20 with strobe 4'b0011 over 0x11223344, then fetch 0x20 → returns 0x1122BEEF.
